// File: rtl/dmg_oam_dma.sv
// DMG OAM DMA controller: a write to FF46 copies XFER_LEN bytes from {src,8'h00} into OAM.
// Optional macro DMG_DMA_RESTART_EN: a write during an active transfer restarts it from the new source.
module dmg_oam_dma #(
    parameter int XFER_LEN = 160,
    parameter int MCYC     = 4
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ff46_wr,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        dma_run,
    output logic        dma_addr_ext,
    output logic        vram_to_oam,
    output logic [15:0] dma_a,
    output logic [7:0]  oam_a,
    output logic        oam_wr
);

    localparam int PH_W = (MCYC > 2) ? $clog2(MCYC) : 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(MCYC - 1);
    localparam logic [7:0]      IDX_LAST = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t          state, state_n;
    logic [7:0]      src, src_n;
    logic [7:0]      run_src, run_src_n;   // source of the transfer currently on the bus
    logic [7:0]      idx, idx_n;
    logic [PH_W-1:0] ph, ph_n;             // phase of the running transfer
    logic [PH_W-1:0] sph, sph_n;           // phase of the START M-cycle
    logic            run_n, oam_wr_n;
    logic [7:0]      eff_src;
    logic            is_vram;

    // An active transfer keeps counting even while a restart's START M-cycle runs alongside it.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n   = state;
        src_n     = src;
        run_src_n = run_src;
        idx_n     = idx;
        ph_n      = ph;
        sph_n     = sph;
        run_n     = dma_run;

        if (dma_run) begin
            if (ph == PH_LAST) begin
                ph_n = '0;
                if (idx == IDX_LAST) begin
                    run_n = 1'b0;
                    idx_n = 8'h00;
                end else begin
                    idx_n = idx + 8'd1;
                end
            end else begin
                ph_n = ph + 1'b1;
            end
        end

        case (state)
            START: begin
                if (sph == PH_LAST) begin
                    state_n = RUN;
                    run_n   = 1'b1;
                    idx_n   = 8'h00;
                    ph_n    = '0;
`ifdef DMG_DMA_RESTART_EN
                    run_src_n = src;
`endif
                end else begin
                    sph_n = sph + 1'b1;
                end
            end
            RUN:     if (!run_n) state_n = IDLE;
            default: ;
        endcase

        if (ff46_wr) begin
            src_n = d_in;
            if (state == IDLE) begin
                state_n = START;
                sph_n   = '0;
`ifndef DMG_DMA_RESTART_EN
                run_src_n = d_in;
`endif
            end
`ifdef DMG_DMA_RESTART_EN
            else begin
                state_n = START;
                sph_n   = '0;
            end
`endif
        end

        // Strobe is registered: high for the clk whose closing edge writes the byte.
        oam_wr_n = run_n && (ph_n == PH_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            src     <= 8'h00;
            run_src <= 8'h00;
            idx     <= 8'h00;
            ph      <= '0;
            sph     <= '0;
            dma_run <= 1'b0;
            oam_wr  <= 1'b0;
        end else begin
            state   <= state_n;
            src     <= src_n;
            run_src <= run_src_n;
            idx     <= idx_n;
            ph      <= ph_n;
            sph     <= sph_n;
            dma_run <= run_n;
            oam_wr  <= oam_wr_n;
        end
    end

    // Echo RAM E000-FDFF mirrors work RAM C000-DDFF.
    assign eff_src = (run_src >= 8'hE0) ? (run_src - 8'h20) : run_src;
    assign is_vram = (eff_src[7:5] == 3'b100);

    assign d_out        = src;
    assign dma_a        = dma_run ? {eff_src, idx} : 16'h0000;
    assign oam_a        = dma_run ? idx : 8'h00;
    assign vram_to_oam  = dma_run && is_vram;
    assign dma_addr_ext = dma_run && !is_vram;

endmodule

// File: tb/tb_dmg_oam_dma.sv
// Directed bench for dmg_oam_dma: reset, basic, VRAM, echo-mirror and restart transfers.
module tb_dmg_oam_dma;

    logic        clk = 1'b0;
    logic        nreset;
    logic        ff46_wr;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        dma_run;
    logic        dma_addr_ext;
    logic        vram_to_oam;
    logic [15:0] dma_a;
    logic [7:0]  oam_a;
    logic        oam_wr;

    int total = 0;
    int bad   = 0;

    logic [15:0] cap_a[$];
    logic [7:0]  cap_o[$];
    int          cap_k[$];
    int          run_cnt, rise_k, falls, sel_err;

    dmg_oam_dma dut (
        .clk          (clk),
        .nreset       (nreset),
        .ff46_wr      (ff46_wr),
        .d_in         (d_in),
        .d_out        (d_out),
        .dma_run      (dma_run),
        .dma_addr_ext (dma_addr_ext),
        .vram_to_oam  (vram_to_oam),
        .dma_a        (dma_a),
        .oam_a        (oam_a),
        .oam_wr       (oam_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write is sampled on the next rising edge (edge 0).
    task automatic write_ff46(input logic [7:0] v);
        ff46_wr = 1'b1;
        d_in    = v;
        @(negedge clk);
        ff46_wr = 1'b0;
        d_in    = 8'h00;
    endtask

    // Samples ncyc consecutive negedges (k=0 is the current one) and records every strobe.
    task automatic watch(input int ncyc, input logic exp_vram);
        logic prev;
        cap_a.delete(); cap_o.delete(); cap_k.delete();
        run_cnt = 0; rise_k = -1; falls = 0; sel_err = 0;
        prev = dma_run;
        for (int k = 0; k < ncyc; k++) begin
            if (dma_run) begin
                run_cnt++;
                if (rise_k < 0) rise_k = k;
                if (vram_to_oam !== exp_vram || dma_addr_ext !== !exp_vram) sel_err++;
            end else if (vram_to_oam !== 1'b0 || dma_addr_ext !== 1'b0) begin
                sel_err++;
            end
            if (prev && !dma_run) falls++;
            if (oam_wr) begin
                cap_a.push_back(dma_a);
                cap_o.push_back(oam_a);
                cap_k.push_back(k);
            end
            prev = dma_run;
            @(negedge clk);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] hi, input int first, input int n);
        int errs = 0;
        check({tag, "_count"}, cap_a.size(), n);
        foreach (cap_a[i]) begin
            if (cap_a[i] !== {hi, 8'(first + i)}) errs++;
            if (cap_o[i] !== 8'(first + i)) errs++;
        end
        check({tag, "_addr_errs"}, errs, 0);
        if (cap_a.size() > 0) check({tag, "_last_a"}, cap_a[cap_a.size()-1], {hi, 8'(first + n - 1)});
    endtask

    task automatic wait_byte(input string tag, input logic need_wr, input logic [7:0] n);
        bit found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            if (dma_run && oam_a == n && (!need_wr || oam_wr)) found = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_reached"}, found, 1'b1);
    endtask

    initial begin
        nreset  = 1'b0;
        ff46_wr = 1'b0;
        d_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs", {d_out, dma_run, dma_addr_ext, vram_to_oam, dma_a, oam_a, oam_wr}, 64'h0);
        nreset = 1'b1;
        @(negedge clk);

        // Basic transfer from work RAM
        write_ff46(8'hC1);
        check("c1_dout", d_out, 8'hC1);
        watch(660, 1'b0);
        check("c1_rise_k", rise_k, 4);
        check("c1_run_clks", run_cnt, 640);
        check("c1_falls", falls, 1);
        check("c1_sel_err", sel_err, 0);
        if (cap_k.size() > 0) check("c1_first_wr_k", cap_k[0], 7);
        check_bytes("c1", 8'hC1, 0, 160);

        // VRAM source
        write_ff46(8'h8A);
        watch(660, 1'b1);
        check("8a_run_clks", run_cnt, 640);
        check("8a_sel_err", sel_err, 0);
        check_bytes("8a", 8'h8A, 0, 160);

        // Echo mirror
        write_ff46(8'hF3);
        check("f3_dout", d_out, 8'hF3);
        watch(660, 1'b0);
        check("f3_sel_err", sel_err, 0);
        check_bytes("f3", 8'hD3, 0, 160);

        // Write on the byte-50 strobe edge
        write_ff46(8'hC0);
        wait_byte("rs", 1'b1, 8'd50);
        check("rs_b50_a", dma_a, 16'hC032);
        write_ff46(8'hD0);
        check("rs_dout", d_out, 8'hD0);
        watch(700, 1'b0);
        check("rs_falls", falls, 1);
        check("rs_sel_err", sel_err, 0);
`ifdef DMG_DMA_RESTART_EN
        check("rs_run_clks", run_cnt, 644);
        check("rs_b51_a", (cap_a.size() > 0) ? cap_a[0] : 16'hDEAD, 16'hC033);
        check("rs_b51_o", (cap_o.size() > 0) ? cap_o[0] : 8'hEE, 8'd51);
        if (cap_a.size() > 0) begin
            void'(cap_a.pop_front());
            void'(cap_o.pop_front());
        end
        check_bytes("rs_new", 8'hD0, 0, 160);
`else
        check("rs_run_clks", run_cnt, 436);
        check_bytes("rs_old", 8'hC0, 51, 109);
`endif

        // Asynchronous reset mid-transfer
        write_ff46(8'hC1);
        wait_byte("rst", 1'b0, 8'd37);
        #2 nreset = 1'b0;
        #1 check("rst_outs", {d_out, dma_run, dma_addr_ext, vram_to_oam, dma_a, oam_a, oam_wr}, 64'h0);
        @(negedge clk);
        nreset = 1'b1;
        watch(60, 1'b0);
        check("rst_no_wr", cap_a.size(), 0);
        check("rst_no_run", run_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
